// File: rtl/conv2d_window_engine_pkg.sv
// conv_pkg: shared state encoding, fixed-point defaults and helpers for the window engine.
// CONV2D_SAT_EN selects saturating scaling in conv_scale.
package conv_pkg;
    localparam int CONV_DATA_W = 16;
    localparam int CONV_FRAC_W = 8;
    localparam int CONV_ACC_W  = 40;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_DRAIN, S_EMIT, S_FIN} conv_state_t;

    typedef struct packed {
        logic                   sat;
        logic [CONV_DATA_W-1:0] data;
    } scale_t;

    function automatic logic [15:0] conv_out_size(input logic [15:0] n, input logic [15:0] k, input logic [1:0] s);
        return (s == 2'd2) ? ((n - k) >> 1) + 16'd1 : n - k + 16'd1;
    endfunction

    function automatic scale_t conv_scale(input logic signed [CONV_ACC_W-1:0] acc);
`ifdef CONV2D_SAT_EN
        logic signed [CONV_ACC_W-1:0] sh;
        logic [CONV_ACC_W-CONV_DATA_W:0] hi;
        sh = acc >>> CONV_FRAC_W;
        hi = sh[CONV_ACC_W-1:CONV_DATA_W-1];
        conv_scale.sat  = !(&hi) && (|hi);
        conv_scale.data = !conv_scale.sat ? sh[CONV_DATA_W-1:0] :
                          sh[CONV_ACC_W-1] ? {1'b1, {(CONV_DATA_W-1){1'b0}}} : {1'b0, {(CONV_DATA_W-1){1'b1}}};
`else
        conv_scale.sat  = 1'b0;
        conv_scale.data = CONV_DATA_W'(acc >>> CONV_FRAC_W);
`endif
    endfunction
endpackage

// File: rtl/conv2d_window_engine_if.sv
// conv2d_window_engine_if: control, pixel-memory and result-stream bundle of the window engine.
// CONV2D_SAT_EN adds the sticky sat_flag output.
interface conv2d_window_engine_if #(
    parameter int DATA_W = 16,
    parameter int MAX_K  = 5,
    parameter int ADDR_W = 10
);
    logic                     start;
    logic [15:0]              img_size;
    logic [15:0]              k_size;
    logic [1:0]               stride;
    logic signed [DATA_W-1:0] filter [MAX_K*MAX_K];
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_rd;
    logic signed [DATA_W-1:0] mem_data;
    logic signed [DATA_W-1:0] out_data;
    logic [15:0]              out_row;
    logic [15:0]              out_col;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;
    logic                     done;
    logic                     err;
`ifdef CONV2D_SAT_EN
    logic                     sat_flag;
`endif

    modport master (
        input  start, img_size, k_size, stride, filter, mem_data, out_ready,
`ifdef CONV2D_SAT_EN
        output sat_flag,
`endif
        output mem_addr, mem_rd, out_data, out_row, out_col, out_valid, busy, done, err
    );

    modport slave (
        output start, img_size, k_size, stride, filter, mem_data, out_ready,
`ifdef CONV2D_SAT_EN
        input  sat_flag,
`endif
        input  mem_addr, mem_rd, out_data, out_row, out_col, out_valid, busy, done, err
    );
endinterface

// File: rtl/conv2d_window_engine_mac.sv
// conv_mac_unit: signed multiply-accumulate with clear and enable, presenting the fixed-point scaled result.
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int ACC_W  = CONV_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output scale_t                   res
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;

    assign prod = a * b;
    assign res  = conv_scale(acc);

    always_ff @(posedge clk)
        acc <= (reset || clr) ? '0 : en ? acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : acc;
endmodule

// File: rtl/conv2d_window_engine.sv
// conv2d_window_engine: serial KxK window convolver over a 1-cycle-latency pixel memory, row-major valid/ready output.
// CONV2D_SAT_EN: saturate results and raise sticky sat_flag on clipping; otherwise results wrap.
module conv2d_window_engine
    import conv_pkg::*;
#(
    parameter int DATA_W  = CONV_DATA_W,
    parameter int FRAC_W  = CONV_FRAC_W,
    parameter int MAX_IMG = 32,
    parameter int MAX_K   = 5,
    parameter int ACC_W   = CONV_ACC_W,
    parameter int ADDR_W  = $clog2(MAX_IMG*MAX_IMG)
) (
    input logic clk,
    input logic reset,
    conv2d_window_engine_if.master bus
);
    localparam int FW = $clog2(MAX_K*MAX_K);

    conv_state_t              state, nxt;
    logic [15:0]              n, k, o, row, col, wr, wc;
    logic [1:0]               s;
    logic signed [DATA_W-1:0] coef [MAX_K*MAX_K];
    logic [FW-1:0]            f, f_d, last_f;
    logic                     rd_d, bad, xfer, last_out;
    logic [31:0]              pr, pc;
    scale_t                   res;

    assign bad      = !k[0] || k > 16'(MAX_K) || n < k || n > 16'(MAX_IMG) || (s != 2'd1 && s != 2'd2);
    assign last_f   = FW'(k * k - 16'd1);
    assign xfer     = state == S_EMIT && bus.out_ready;
    assign last_out = row == o - 16'd1 && col == o - 16'd1;
    assign pr       = 32'(row) * 32'(s) + 32'(wr);
    assign pc       = 32'(col) * 32'(s) + 32'(wc);

    assign bus.mem_addr  = state == S_FETCH ? ADDR_W'(pr * 32'(n) + pc) : '0;
    assign bus.mem_rd    = state == S_FETCH;
    assign bus.out_valid = state == S_EMIT;
    assign bus.out_data  = state == S_EMIT ? res.data : '0;
    assign bus.out_row   = row;
    assign bus.out_col   = col;
    assign bus.busy      = state != S_IDLE && state != S_FIN;
    assign bus.done      = state == S_FIN;

    conv_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) mac (
        .clk(clk), .reset(reset), .clr(xfer), .en(rd_d),
        .a(bus.mem_data), .b(coef[f_d]), .res(res)
    );

    always_ff @(posedge clk)
        state <= reset ? S_IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = bus.start ? S_CHECK : S_IDLE;
            S_CHECK: nxt = bad ? S_FIN : S_FETCH;
            S_FETCH: nxt = f == last_f ? S_DRAIN : S_FETCH;
            S_DRAIN: nxt = S_EMIT;
            S_EMIT:  nxt = !bus.out_ready ? S_EMIT : last_out ? S_FIN : S_FETCH;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {n, k, o, row, col, wr, wc} <= '0;
            s       <= '0;
            f       <= '0;
            f_d     <= '0;
            rd_d    <= 1'b0;
            coef    <= '{default: '0};
            bus.err <= 1'b0;
        end else begin
            f_d  <= f;
            rd_d <= state == S_FETCH;
            if (state == S_IDLE && bus.start) begin
                n       <= bus.img_size;
                k       <= bus.k_size;
                s       <= bus.stride;
                coef    <= bus.filter;
                row     <= '0;
                col     <= '0;
                bus.err <= 1'b0;
            end
            if (state == S_CHECK) begin
                bus.err <= bad;
                o       <= conv_out_size(n, k, s);
            end
            if (state == S_FETCH) begin
                f  <= f + FW'(1);
                wc <= wc == k - 16'd1 ? '0 : wc + 16'd1;
                wr <= wc == k - 16'd1 ? wr + 16'd1 : wr;
            end
            if (xfer) begin
                f   <= '0;
                wr  <= '0;
                wc  <= '0;
                col <= col == o - 16'd1 ? '0 : col + 16'd1;
                row <= col == o - 16'd1 ? row + 16'd1 : row;
            end
        end
    end

`ifdef CONV2D_SAT_EN
    always_ff @(posedge clk)
        bus.sat_flag <= (reset || (state == S_IDLE && bus.start)) ? 1'b0 : bus.sat_flag || (xfer && res.sat);
`else
    logic unused_sat;
    assign unused_sat = res.sat;
`endif
endmodule
